// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the CPU boot sequencer: FSM state encoding,
// instruction-memory word stride and default parameter values.
package cpu_boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RELEASE,
      RUN,
      HALT,
      ERR
   } boot_state_e;

   localparam int IMEM_STRIDE        = 4;
   localparam int DEF_IMEM_WORDS     = 64;
   localparam int DEF_HALT_WINDOW    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 4096;
   localparam int DEF_CYC_W          = 32;

endpackage

// File: rtl/cpu_boot_ctrl_halt_detect.sv
// Self-loop detector: counts consecutive cycles where the CPU PC repeats and
// flags when that count reaches HALT_WINDOW.
module cpu_halt_detect
   import cpu_boot_pkg::*;
#(
   parameter int HALT_WINDOW = DEF_HALT_WINDOW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        en,
   input  logic [31:0] pc,
   output logic        stable
);

   localparam int CNT_W = $clog2(HALT_WINDOW + 1);

   logic [31:0]      prevPc_q;
   logic             havePrev_q;
   logic [CNT_W-1:0] stableCnt_q;
   logic [CNT_W-1:0] stableCnt_d;
   logic             samePc;

   // The very first sample after a clear has nothing to compare against.
   assign samePc = havePrev_q && (pc == prevPc_q);

   always_comb begin
      stableCnt_d = stableCnt_q;
      if (en) begin
         if (!samePc) begin
            stableCnt_d = '0;
         end else if (stableCnt_q != CNT_W'(HALT_WINDOW)) begin
            stableCnt_d = stableCnt_q + 1'b1;
         end
      end
   end

   assign stable = en && samePc && (stableCnt_d == CNT_W'(HALT_WINDOW));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prevPc_q    <= '0;
         havePrev_q  <= 1'b0;
         stableCnt_q <= '0;
      end else if (clear) begin
         havePrev_q  <= 1'b0;
         stableCnt_q <= '0;
      end else if (en) begin
         prevPc_q    <= pc;
         havePrev_q  <= 1'b1;
         stableCnt_q <= stableCnt_d;
      end
   end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: streams a program into instruction memory, releases the CPU,
// and watches for a PC self-loop. Optional CPU_BOOT_CHECKSUM_EN adds load_csum.
module cpu_boot_ctrl
   import cpu_boot_pkg::*;
#(
   parameter int IMEM_WORDS     = DEF_IMEM_WORDS,
   parameter int HALT_WINDOW    = DEF_HALT_WINDOW,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CYC_W          = DEF_CYC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [31:0]      load_data,
   input  logic             load_last,
   output logic             imem_init,
   output logic [31:0]      imem_wr_addr,
   output logic [31:0]      imem_wr_data,
   output logic             cpu_rst,
   input  logic [31:0]      cpu_pc,
   output logic             busy,
   output logic             halted,
   output logic             error,
   output logic [CYC_W-1:0] run_cycles
`ifdef CPU_BOOT_CHECKSUM_EN
   ,
   output logic [31:0]      load_csum
`endif
);

   localparam int CNT_W = $clog2(IMEM_WORDS + 1);

   boot_state_e      state_q;
   boot_state_e      state_d;
   logic [CNT_W-1:0] wordCount_q;
   logic [31:0]      wrAddr_q;
   logic [31:0]      wrData_q;
   logic [CYC_W-1:0] runCycles_q;
   logic [CYC_W-1:0] runInc;
   logic             loadReady_q;
   logic             imemInit_q;
   logic             cpuRst_q;
   logic             busy_q;
   logic             halted_q;
   logic             error_q;
   logic             handshake;
   logic             overflow;
   logic             timedOut;
   logic             haltSeen;
   logic             enterLoad;

   assign handshake = load_valid && loadReady_q;
   assign overflow  = (wordCount_q == CNT_W'(IMEM_WORDS));
   assign runInc    = (&runCycles_q) ? runCycles_q : runCycles_q + 1'b1;
   assign timedOut  = (runInc == CYC_W'(TIMEOUT_CYCLES));
   assign enterLoad = (state_q != LOAD) && (state_d == LOAD);

   cpu_halt_detect #(
      .HALT_WINDOW(HALT_WINDOW)
   ) u_halt_detect (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == RELEASE),
      .en    (state_q == RUN),
      .pc    (cpu_pc),
      .stable(haltSeen)
   );

   // An overflowing word is never written, even if it also carries load_last.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, HALT, ERR: if (load_start) state_d = LOAD;
         LOAD: begin
            if (handshake) begin
               if (overflow)       state_d = ERR;
               else if (load_last) state_d = RELEASE;
            end
         end
         RELEASE: state_d = RUN;
         RUN: begin
            if (haltSeen)      state_d = HALT;
            else if (timedOut) state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wordCount_q <= '0;
         wrAddr_q    <= '0;
         wrData_q    <= '0;
         runCycles_q <= '0;
         loadReady_q <= 1'b0;
         imemInit_q  <= 1'b1;
         cpuRst_q    <= 1'b1;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         loadReady_q <= (state_d == LOAD);
         imemInit_q  <= state_d inside {IDLE, LOAD, RELEASE, ERR};
         cpuRst_q    <= state_d inside {IDLE, LOAD, RELEASE, ERR};
         busy_q      <= state_d inside {LOAD, RELEASE, RUN};
         halted_q    <= (state_d == HALT);
         error_q     <= (state_d == ERR);

         if (enterLoad) begin
            wordCount_q <= '0;
         end else if (handshake && !overflow) begin
            wrData_q    <= load_data;
            wrAddr_q    <= 32'(wordCount_q) * 32'(IMEM_STRIDE);
            wordCount_q <= wordCount_q + 1'b1;
         end

         if (state_q == RELEASE) begin
            runCycles_q <= '0;
         end else if (state_q == RUN) begin
            runCycles_q <= runInc;
         end
      end
   end

`ifdef CPU_BOOT_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum_q <= '0;
      end else if (enterLoad) begin
         csum_q <= '0;
      end else if (handshake) begin
         csum_q <= csum_q ^ load_data;
      end
   end

   assign load_csum = csum_q;
`endif

   assign load_ready   = loadReady_q;
   assign imem_init    = imemInit_q;
   assign imem_wr_addr = wrAddr_q;
   assign imem_wr_data = wrData_q;
   assign cpu_rst      = cpuRst_q;
   assign busy         = busy_q;
   assign halted       = halted_q;
   assign error        = error_q;
   assign run_cycles   = runCycles_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: random programs and PC traces checked
// against a behavioural model of loading, halt detection and timeout.
module tb_cpu_boot_ctrl;

   localparam int IW = 16;
   localparam int HW = 2;
   localparam int TO = 40;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic          load_valid;
   logic          load_ready;
   logic [31:0]   load_data;
   logic          load_last;
   logic          imem_init;
   logic [31:0]   imem_wr_addr;
   logic [31:0]   imem_wr_data;
   logic          cpu_rst;
   logic [31:0]   cpu_pc;
   logic          busy;
   logic          halted;
   logic          error;
   logic [CW-1:0] run_cycles;
`ifdef CPU_BOOT_CHECKSUM_EN
   logic [31:0]   load_csum;
`endif

   int            vectors = 0;
   int            miscompares = 0;
   logic [31:0]   modelAddr;
   logic [31:0]   modelData;
   logic [31:0]   modelCsum;
   logic [31:0]   fixedWords[$];

   always #5 clk = ~clk;

   cpu_boot_ctrl #(
      .IMEM_WORDS(IW),
      .HALT_WINDOW(HW),
      .TIMEOUT_CYCLES(TO),
      .CYC_W(CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .load_last   (load_last),
      .imem_init   (imem_init),
      .imem_wr_addr(imem_wr_addr),
      .imem_wr_data(imem_wr_data),
      .cpu_rst     (cpu_rst),
      .cpu_pc      (cpu_pc),
      .busy        (busy),
      .halted      (halted),
      .error       (error),
      .run_cycles  (run_cycles)
`ifdef CPU_BOOT_CHECKSUM_EN
      ,
      .load_csum   (load_csum)
`endif
   );

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic valid,
                                input logic [31:0] data, input logic last,
                                input logic [31:0] pc);
      load_start = start;
      load_valid = valid;
      load_data  = data;
      load_last  = last;
      cpu_pc     = pc;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic rdy, input logic init,
                             input logic crst, input logic bsy, input logic hlt,
                             input logic err);
      checkOutput({tag, ".load_ready"}, load_ready, rdy);
      checkOutput({tag, ".imem_init"},  imem_init,  init);
      checkOutput({tag, ".cpu_rst"},    cpu_rst,    crst);
      checkOutput({tag, ".busy"},       busy,       bsy);
      checkOutput({tag, ".halted"},     halted,     hlt);
      checkOutput({tag, ".error"},      error,      err);
   endtask

   // Streams n words with random bubbles; a word beyond IW must be refused.
   task automatic loadProgram(input string tag, input int n, input logic withLast);
      logic [31:0] word;
      logic        isLast;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      load_start = 1'b0;
      modelCsum  = 32'h0;
      checkState({tag, ".enter"}, 1, 1, 1, 1, 0, 0);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            applyStimulus(1'b0, 1'b0, $urandom, 1'b1, 32'h0);
            tick();
            checkOutput({tag, ".gap_addr"}, imem_wr_addr, modelAddr);
            checkOutput({tag, ".gap_data"}, imem_wr_data, modelData);
         end
         word   = (fixedWords.size() > 0) ? fixedWords.pop_front() : $urandom;
         isLast = withLast && (i == n - 1);
         applyStimulus(1'b0, 1'b1, word, isLast, 32'h0);
         tick();
         load_valid = 1'b0;
         modelCsum  = modelCsum ^ word;
         if (i < IW) begin
            modelAddr = 32'(i * 4);
            modelData = word;
            checkOutput({tag, ".wr_addr"}, imem_wr_addr, modelAddr);
            checkOutput({tag, ".wr_data"}, imem_wr_data, modelData);
            if (isLast) checkState({tag, ".release"}, 0, 1, 1, 1, 0, 0);
            else        checkState({tag, ".load"},    1, 1, 1, 1, 0, 0);
         end else begin
            checkOutput({tag, ".ovf_addr"}, imem_wr_addr, modelAddr);
            checkState({tag, ".ovf"}, 0, 1, 1, 0, 0, 1);
         end
      end
      if (withLast && n <= IW) begin
`ifdef CPU_BOOT_CHECKSUM_EN
         checkOutput({tag, ".csum"}, load_csum, modelCsum);
`endif
         tick();
         checkState({tag, ".run0"}, 0, 0, 0, 1, 0, 0);
         checkOutput({tag, ".run0_cycles"}, run_cycles, 0);
      end
   endtask

   // mode 0: one step then self-loop; mode 1: never loops; mode 2: random PCs.
   task automatic runProgram(input string tag, input int mode);
      logic [31:0] trace[TO];
      int          endIdx;
      logic        halts;
      logic        allSame;
      for (int k = 0; k < TO; k++) begin
         case (mode)
            0:       trace[k] = (k == 0) ? 32'h0 : 32'h4;
            1:       trace[k] = 32'(k * 4);
            default: trace[k] = (k > 0 && $urandom_range(0, 2) != 0) ? trace[k-1]
                                : 32'(4 * $urandom_range(0, 7));
         endcase
      end
      halts  = 1'b0;
      endIdx = TO - 1;
      for (int k = HW; k < TO && !halts; k++) begin
         allSame = 1'b1;
         for (int j = 1; j <= HW; j++) if (trace[k-j] != trace[k]) allSame = 1'b0;
         if (allSame) begin
            halts  = 1'b1;
            endIdx = k;
         end
      end
      for (int k = 0; k <= endIdx; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0, trace[k]);
         tick();
         load_start = 1'b0;
         checkOutput({tag, ".cycles"}, run_cycles, 64'(k + 1));
         if (k < endIdx)  checkState({tag, ".run"},  0, 0, 0, 1, 0, 0);
         else if (halts)  checkState({tag, ".halt"}, 0, 0, 0, 0, 1, 0);
         else             checkState({tag, ".tmo"},  0, 1, 1, 0, 0, 1);
      end
      for (int r = 0; r < 3; r++) begin
         cpu_pc = $urandom;
         tick();
         checkOutput({tag, ".frozen"}, run_cycles, 64'(endIdx + 1));
         checkOutput({tag, ".hold_halt"}, halted, halts);
         checkOutput({tag, ".hold_err"}, error, !halts);
      end
   endtask

   initial begin
      modelAddr = 32'h0;
      modelData = 32'h0;
      modelCsum = 32'h0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      rst = 1'b1;
      #1 rst = 1'b0;
      #11;
      checkState("reset", 0, 1, 1, 0, 0, 0);
      checkOutput("reset.addr", imem_wr_addr, 0);
      checkOutput("reset.data", imem_wr_data, 0);
      checkOutput("reset.cycles", run_cycles, 0);
      rst = 1'b1;
      tick();

      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0);
      tick();
      load_valid = 1'b0;
      checkState("idle_ignores_valid", 0, 1, 1, 0, 0, 0);

      loadProgram("boot10", 10, 1'b1);
      runProgram("selfloop", 0);

      fixedWords.push_back(32'h1);
      fixedWords.push_back(32'h3);
      loadProgram("from_halt", 2, 1'b1);
      runProgram("straight", 1);

      loadProgram("overflow", IW + 1, 1'b0);

      loadProgram("partial", 2, 1'b0);
      rst = 1'b0;
      #1;
      modelAddr = 32'h0;
      modelData = 32'h0;
      checkState("midreset", 0, 1, 1, 0, 0, 0);
      checkOutput("midreset.addr", imem_wr_addr, 0);
      checkOutput("midreset.data", imem_wr_data, 0);
      checkOutput("midreset.cycles", run_cycles, 0);
      rst = 1'b1;
      tick();
      loadProgram("reload3", 3, 1'b1);
      runProgram("rand0", 2);

      loadProgram("single", 1, 1'b1);
      runProgram("rand1", 2);

      for (int t = 0; t < 6; t++) begin
         loadProgram("randload", $urandom_range(1, IW), 1'b1);
         runProgram("randrun", 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
